// File: rtl/aes_sbox_rom_arbiter.sv
// Arbitrates two 32-bit S-box word requesters onto one external 256x8 ROM, four byte lookups per word.
// Define SBOX_ARB_FIXED_PRIO_EN for fixed priority to requester 0 instead of round-robin.
module aes_sbox_rom_arbiter #(
    parameter int ROM_WAIT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0,
    input  logic [31:0] i_word0,
    output logic        o_ack0,
    input  logic        i_req1,
    input  logic [31:0] i_word1,
    output logic        o_ack1,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic [7:0]  o_rom_addr,
    input  logic [7:0]  i_rom_data,
    output logic        o_rom_ce_n,
    output logic        o_rom_oe_n
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOOK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_INIT = ROM_WAIT[2:0];

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_gnt_vld;
    logic        w_gnt;
    logic        r_gnt;
    logic        r_last_grant;
    logic [23:0] r_rest;
    logic [1:0]  r_byte_idx;
    logic [2:0]  r_wcnt;
    logic [31:0] r_rdata;
    logic [7:0]  r_rom_addr;
    logic        r_ce_n;
    logic        r_ack0;
    logic        r_ack1;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_vld   = 1'b0;
        w_gnt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    w_gnt_vld = 1'b1;
                    if (i_req0 && i_req1) begin
`ifdef SBOX_ARB_FIXED_PRIO_EN
                        w_gnt = 1'b0;
`else
                        w_gnt = ~r_last_grant;
`endif
                    end else begin
                        w_gnt = i_req1;
                    end
                    w_state_nxt = S_LOOK;
                end
            end
            S_LOOK: begin
                if (r_wcnt == 3'd0 && r_byte_idx == 2'd3)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_gnt        <= 1'b0;
            r_last_grant <= 1'b1;
            r_rest       <= 24'h0;
            r_byte_idx   <= 2'd0;
            r_wcnt       <= 3'd0;
            r_rdata      <= 32'h0;
            r_rom_addr   <= 8'h00;
            r_ce_n       <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt        <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_rom_addr   <= w_gnt ? i_word1[31:24] : i_word0[31:24];
                        r_rest       <= w_gnt ? i_word1[23:0]  : i_word0[23:0];
                        r_ce_n       <= 1'b0;
                        r_byte_idx   <= 2'd0;
                        r_wcnt       <= WAIT_INIT;
                    end
                end
                S_LOOK: begin
                    if (r_wcnt != 3'd0) begin
                        r_wcnt <= r_wcnt - 3'd1;
                    end else begin
                        case (r_byte_idx)
                            2'd0:    r_rdata[31:24] <= i_rom_data;
                            2'd1:    r_rdata[23:16] <= i_rom_data;
                            2'd2:    r_rdata[15:8]  <= i_rom_data;
                            default: r_rdata[7:0]   <= i_rom_data;
                        endcase
                        // Remaining bytes sit MSB-aligned in r_rest, so the next address is always [23:16].
                        if (r_byte_idx != 2'd3) begin
                            r_rom_addr <= r_rest[23:16];
                            r_rest     <= {r_rest[15:0], 8'h00};
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_wcnt     <= WAIT_INIT;
                        end else begin
                            r_ce_n <= 1'b1;
                            r_ack0 <= ~r_gnt;
                            r_ack1 <= r_gnt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ack0     = r_ack0;
    assign o_ack1     = r_ack1;
    assign o_rdata    = r_rdata;
    assign o_busy     = (r_state != S_IDLE);
    assign o_rom_addr = r_rom_addr;
    assign o_rom_ce_n = r_ce_n;
    assign o_rom_oe_n = r_ce_n;
endmodule
